// File: rtl/alu_dispatch_24bit.sv
// ALU operation dispatcher: one-hot unit select plus a registered result, with a shift-add multiplier for MUL.
// Latency: non-MUL result is valid on the edge after accept; MUL result is valid WIDTH edges after accept.
// Backpressure: in_ready drops while an op is in flight; the result is held in DONE until out_ready.
module alu_dispatch_24bit #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [7:0]       unit_sel,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [7:0]       unit_sel_q, unit_sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_sum;
  logic [4:0]       shamt;

  // Reset gates in_ready so no request is taken while reset is applied.
  assign in_ready   = (state_q == S_IDLE) && !reset;
  assign busy       = (state_q == S_BUSY);
  assign out_valid  = (state_q == S_DONE);
  assign unit_sel   = unit_sel_q;
  assign out_result = result_q;
  assign out_err    = err_q;

  assign shamt   = in_b[4:0];
  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle result for every opcode except MUL (MUL is handled by the iteration path).
  always_comb begin
    alu_res = '0;
    case (in_sel)
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_ADD: alu_res = in_a + in_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_XOR: alu_res = in_a ^ in_b;
      OP_SLL: alu_res = (int'(shamt) >= WIDTH) ? '0 : (in_a << shamt);
      default: alu_res = '0;
    endcase
  end

  // Next-state and datapath-register update for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    unit_sel_d = unit_sel_q;
    result_d   = result_q;
    err_d      = err_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          unit_sel_d = 8'd1 << in_sel;
          if (in_sel == OP_MUL) begin
            mcand_d  = in_a;
            mplier_d = in_b;
            acc_d    = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
            state_d  = S_BUSY;
          end else begin
            result_d = alu_res;
            err_d    = (in_sel == OP_ILL);
            state_d  = S_DONE;
          end
        end
      end
      S_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = acc_sum;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // Result and error flag stay visible after the handshake; only the unit select clears.
        if (out_ready) begin
          unit_sel_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      unit_sel_q <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      unit_sel_q <= unit_sel_d;
      result_q   <= result_d;
      err_q      <= err_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_dispatch_24bit.sv
// Bench for alu_dispatch_24bit: directed vector table, hand sequences for backpressure and reset, random ops vs model.
// Latency: checks 0 extra edges for non-MUL and 24 edges for MUL between accept and out_valid.
// Backpressure: holds out_ready low in DONE and checks the payload stays frozen.
module tb_alu_dispatch_24bit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic [7:0]  unit_sel;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_result;
  logic        out_err;

  int checks   = 0;
  int failures = 0;

  alu_dispatch_24bit #(.WIDTH(24), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_a       (in_a),
    .in_b       (in_b),
    .unit_sel   (unit_sel),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the opcode meaning; returns {err, result}.
  function automatic logic [24:0] model(input logic [2:0] sel, input logic [23:0] a, input logic [23:0] b);
    logic [47:0] prod;
    logic [24:0] sum;
    int          sh;
    model = '0;
    case (sel)
      3'd0: model = {1'b0, a & b};
      3'd1: model = {1'b0, a | b};
      3'd2: begin sum = {1'b0, a} + {1'b0, b}; model = {1'b0, sum[23:0]}; end
      3'd3: model = ($signed(a) < $signed(b)) ? 25'd1 : 25'd0;
      3'd4: begin prod = {24'd0, a} * {24'd0, b}; model = {1'b0, prod[23:0]}; end
      3'd5: model = {1'b0, a ^ b};
      3'd6: begin sh = int'(b[4:0]); model = (sh >= 24) ? 25'd0 : {1'b0, a << sh}; end
      default: model = {1'b1, 24'd0};
    endcase
  endfunction

  // Issue one op, scramble the inputs after accept, wait (bounded) for the result, then consume it.
  task automatic do_op(input logic [2:0] sel, input logic [23:0] a, input logic [23:0] b, input int hold,
                       output logic [23:0] res, output logic err, output logic [7:0] usel,
                       output int lat, output int bcnt, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin tick(); n++; end
    in_valid = 1'b1; in_sel = sel; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    in_sel = 3'($urandom); in_a = 24'($urandom); in_b = 24'($urandom);
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 60) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    ok = out_valid;
    res = out_result; err = out_err; usel = unit_sel;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [23:0] r, r0;
    logic        e;
    logic [7:0]  u, u0;
    int          lat, bcnt, explat;
    bit          ok, stable;
    logic [24:0] m;
    logic [2:0]  s;

    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_a = '0; in_b = '0; out_ready = 1'b0;

    vecs.push_back('{3'd2, 24'hFFFFFF, 24'h000002, 24'h000001, 1'b0, 0});
    vecs.push_back('{3'd3, 24'h800000, 24'h000001, 24'h000001, 1'b0, 0});
    vecs.push_back('{3'd3, 24'h000001, 24'h800000, 24'h000000, 1'b0, 0});
    vecs.push_back('{3'd6, 24'h000001, 24'h00001F, 24'h000000, 1'b0, 0});
    vecs.push_back('{3'd6, 24'h000001, 24'h000017, 24'h800000, 1'b0, 0});
    vecs.push_back('{3'd4, 24'h001234, 24'h000100, 24'h123400, 1'b0, 24});
    vecs.push_back('{3'd4, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 1'b0, 24});
    vecs.push_back('{3'd7, 24'h123456, 24'h654321, 24'h000000, 1'b1, 0});
    vecs.push_back('{3'd0, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 1'b0, 0});
    vecs.push_back('{3'd1, 24'h0F0F0F, 24'hF00000, 24'hFF0F0F, 1'b0, 0});
    vecs.push_back('{3'd5, 24'hAAAAAA, 24'hFFFF00, 24'h5555AA, 1'b0, 0});
    vecs.push_back('{3'd2, 24'h000003, 24'h000004, 24'h000007, 1'b0, 0});

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_unit_sel", 32'(unit_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, r, e, u, lat, bcnt, ok);
      chk($sformatf("vec%0d_seen", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("vec%0d_unit_sel", i), 32'(u), 32'(8'd1 << vecs[i].sel));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
    end

    // Backpressure: result frozen while out_ready is low
    in_valid = 1'b1; in_sel = 3'd2; in_a = 24'd5; in_b = 24'd6;
    tick();
    in_valid = 1'b0; in_a = 24'hABCDEF;
    r0 = out_result; u0 = unit_sel;
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_result", 32'(r0), 32'd11);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_result !== r0 || unit_sel !== u0 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_unit_sel", 32'(unit_sel), 32'd0);
    chk("bp_release_result_held", 32'(out_result), 32'd11);

    // Reset in the middle of a multiply
    in_valid = 1'b1; in_sel = 3'd4; in_a = 24'h001234; in_b = 24'h000100;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("midmul_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midmul_rst_busy", 32'(busy), 32'd0);
    chk("midmul_rst_unit_sel", 32'(unit_sel), 32'd0);
    chk("midmul_rst_valid", 32'(out_valid), 32'd0);
    chk("midmul_rst_result", 32'(out_result), 32'd0);
    chk("midmul_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midmul_release_in_ready", 32'(in_ready), 32'd1);
    repeat (30) tick();
    chk("midmul_no_stale_valid", 32'(out_valid), 32'd0);
    do_op(3'd2, 24'd3, 24'd4, 0, r, e, u, lat, bcnt, ok);
    chk("after_rst_add_result", 32'(r), 32'd7);
    chk("after_rst_add_err", 32'(e), 32'd0);
    chk("after_rst_add_unit_sel", 32'(u), 32'h04);

    // Random ops against the reference model
    for (int k = 0; k < 60; k++) begin
      s = 3'($urandom_range(0, 7));
      in_a = 24'($urandom);
      in_b = 24'($urandom);
      r0 = in_a;
      u0 = 8'($urandom);
      if (s == 3'd6) in_b = {in_b[23:5], 5'($urandom_range(0, 31))};
      m = model(s, r0, in_b);
      explat = (s == 3'd4) ? 24 : 0;
      do_op(s, r0, in_b, int'(u0[1:0]), r, e, u, lat, bcnt, ok);
      chk($sformatf("rnd%0d_seen", k), 32'(ok), 32'd1);
      chk($sformatf("rnd%0d_result op%0d", k, s), 32'(r), 32'(m[23:0]));
      chk($sformatf("rnd%0d_err", k), 32'(e), 32'(m[24]));
      chk($sformatf("rnd%0d_unit_sel", k), 32'(u), 32'(8'd1 << s));
      chk($sformatf("rnd%0d_latency", k), 32'(lat), 32'(explat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
